// File: rtl/key_event_encoder.sv
// Turns the debounced 16-bit key level vector into discrete key events.
// A key press produces {code, repeat=0}. Holding the key produces auto-repeat events.
// Chords of two or more keys are suppressed until every key is released.
// Events pass through a small first-word-fall-through queue with a valid/ready handshake.
// FIFO_DEPTH must be a power of two and at least 2, because the pointers wrap naturally.
module key_event_encoder #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [15:0] key_deb,
  input  logic        ev_ready,
  output logic        ev_valid,
  output logic [3:0]  ev_code,
  output logic        ev_repeat,
  output logic        multi_key,
  output logic        overflow
);

  // Cycle counts are computed in 64 bits because ms * Hz overflows 32 bits at board rates.
  localparam longint unsigned DelayRaw = (64'(REPEAT_DELAY_MS) * 64'(CLK_HZ)) / 64'd1000;
  localparam longint unsigned RateRaw  = (64'(REPEAT_RATE_MS) * 64'(CLK_HZ)) / 64'd1000;
  localparam longint unsigned DelayCyc = (DelayRaw == 0) ? 64'd1 : DelayRaw;
  localparam longint unsigned RateCyc  = (RateRaw == 0) ? 64'd1 : RateRaw;
  localparam longint unsigned MaxCyc   = (DelayCyc > RateCyc) ? DelayCyc : RateCyc;
  localparam int unsigned     CntW     = $clog2(MaxCyc) + 1;

  // The counter runs down to zero, so load N-1 to fire N cycles after the load.
  localparam logic [CntW-1:0] DelayLoad = CntW'(DelayCyc - 64'd1);
  localparam logic [CntW-1:0] RateLoad  = CntW'(RateCyc - 64'd1);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StHold, StRepeat, StMulti} state_e;

  // Input stage
  logic [15:0] key_q;
  logic        key_none;
  logic        key_one;
  logic        key_many;
  logic [3:0]  key_idx;

  // FSM
  state_e          state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            multi_key_q;
  logic            push;
  logic [3:0]      push_code;
  logic            push_rep;

  // FIFO
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_next;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    head_q, head_d;
  logic [4:0]    push_entry;
  logic          overflow_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  // Register the debounced key vector; all classification works on this copy.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      key_q <= '0;
    end else begin
      key_q <= key_deb;
    end
  end

  // Classify the key vector as none / exactly one / several keys held, and find the key index.
  always_comb begin
    key_none = (key_q == 16'd0);
    key_one  = !key_none && ((key_q & (key_q - 16'd1)) == 16'd0);
    key_many = !key_none && !key_one;
    key_idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (key_q[i]) begin
        key_idx = 4'(i);
      end
    end
  end

  // Decide the next press / repeat / chord state and whether an event is pushed this cycle.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_code = key_idx;
    push_rep  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_one) begin
          push    = 1'b1;
          code_d  = key_idx;
          cnt_d   = DelayLoad;
          state_d = StHold;
        end else if (key_many) begin
          state_d = StMulti;
        end
      end
      StHold, StRepeat: begin
        if (key_none) begin
          state_d = StIdle;
        end else if (key_many) begin
          state_d = StMulti;
        end else if (key_idx != code_q) begin
          // Roll-over to another key: new press, and the repeat delay starts again.
          push    = 1'b1;
          code_d  = key_idx;
          cnt_d   = DelayLoad;
          state_d = StHold;
        end else if (cnt_q == '0) begin
          push      = 1'b1;
          push_code = code_q;
          push_rep  = 1'b1;
          cnt_d     = RateLoad;
          state_d   = StRepeat;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StMulti: begin
        // Keys left over after a chord are ignored until everything is released.
        if (key_none) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register the FSM state, the latched key code, the hold counter and the chord flag.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      code_q      <= '0;
      cnt_q       <= '0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      multi_key_q <= (state_d == StMulti);
    end
  end

  // Work out the queue handshake, the occupancy and the next head entry.
  always_comb begin
    push_entry  = {push_code, push_rep};
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CW'(FIFO_DEPTH));
    pop         = !fifo_empty && ev_ready;
    push_ok     = push && (!fifo_full || pop);
    drop        = push && fifo_full && !pop;
    rd_ptr_next = rd_ptr_q + 1'b1;

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end

    // The head register holds its last value when the queue drains.
    head_d = head_q;
    if (push_ok && (fifo_empty || (pop && count_q == CW'(1)))) begin
      head_d = push_entry;
    end else if (pop && count_q > CW'(1)) begin
      head_d = mem_q[rd_ptr_next];
    end
  end

  // Queue storage; the head register and the occupancy count track which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Register the queue pointers, the occupancy, the presented head and the overflow pulse.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_next;
      end
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= drop;
    end
  end

  // Drive the outputs straight from registers.
  always_comb begin
    ev_valid  = (count_q != '0);
    ev_code   = head_q[4:1];
    ev_repeat = head_q[0];
    multi_key = multi_key_q;
    overflow  = overflow_q;
  end

endmodule
